// File: rtl/imem_responder.sv
// Fetch-side instruction memory: accepts a pc, returns the word LATENCY+1 cycles later.
// One fetch in flight; req_ready low until the response handshakes, response held while rsp_ready low.
module imem_responder #(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    output logic                  busy
);

    localparam logic [1:0]  S_IDLE     = 2'd0;
    localparam logic [1:0]  S_WAIT     = 2'd1;
    localparam logic [1:0]  S_RESP     = 2'd2;
    localparam logic [31:0] EBREAK     = 32'h0010_0073;
    localparam logic [32:0] DEPTH_WRDS = 33'd1 << DEPTH_LOG2;
    localparam bit          ZERO_LAT   = (LATENCY == 0);
    localparam logic [3:0]  CNT_INIT   = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    logic [31:0] mem [2**DEPTH_LOG2];

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        enter_resp;

    // With zero latency the read happens on the accept edge, so the live request address is used.
    logic [31:0]           rd_addr;
    logic [31:0]           rd_off;
    logic [31:0]           rd_word_off;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  rd_err;
    logic [31:0]           rd_word;

    always_comb begin
        rd_addr     = (state_q == S_IDLE) ? req_addr : addr_q;
        rd_off      = rd_addr - BASE;
        rd_word_off = rd_off >> 2;
        rd_idx      = rd_word_off[DEPTH_LOG2-1:0];
        // Unsigned compare before subtraction keeps addresses below BASE from wrapping into range.
        rd_err      = (rd_addr[1:0] != 2'b00) || (rd_addr < BASE) ||
                      ({1'b0, rd_word_off} >= DEPTH_WRDS);
        rd_word     = mem[rd_idx];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        enter_resp  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    if (ZERO_LAT) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase

        if (enter_resp) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_err ? EBREAK : rd_word;
            rsp_err_d   = rd_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage is deliberately left out of reset; the loader owns its contents.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Drives three responders (latency 1, 0, 3) from one directed+random sequence against a word-array model.
module tb_imem_responder;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          DEPTH  = 1024;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      req_valid;
    logic [2:0]      rsp_ready;
    logic [2:0][31:0] req_addr;
    logic [2:0]      req_ready_w;
    logic [2:0]      rsp_valid_w;
    logic [2:0]      rsp_err_w;
    logic [2:0]      busy_w;
    logic [2:0][31:0] rsp_data_w;
    logic            ld_en;
    logic [9:0]      ld_addr;
    logic [31:0]     ld_data;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mem_model [DEPTH];
    int          lat_of [3] = '{1, 0, 3};

    always #5 clk = ~clk;

    imem_responder #(.BASE(BASE), .DEPTH_LOG2(10), .LATENCY(1)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready_w[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data_w[0]),
        .rsp_err(rsp_err_w[0]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .busy(busy_w[0]));

    imem_responder #(.BASE(BASE), .DEPTH_LOG2(10), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready_w[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data_w[1]),
        .rsp_err(rsp_err_w[1]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .busy(busy_w[1]));

    imem_responder #(.BASE(BASE), .DEPTH_LOG2(10), .LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready_w[2]), .req_addr(req_addr[2]),
        .rsp_valid(rsp_valid_w[2]), .rsp_ready(rsp_ready[2]), .rsp_data(rsp_data_w[2]),
        .rsp_err(rsp_err_w[2]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .busy(busy_w[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: a fetch is legal only if word aligned and inside [BASE, BASE + 4*DEPTH).
    function automatic void model_rsp(input logic [31:0] a, output logic [31:0] d, output logic e);
        longint unsigned la;
        la = longint'(a);
        if ((la % 4) != 0 || la < longint'(BASE) || la >= longint'(BASE) + 4 * DEPTH) begin
            e = 1'b1;
            d = EBREAK;
        end else begin
            e = 1'b0;
            d = mem_model[int'((la - longint'(BASE)) / 4)];
        end
    endfunction

    task automatic ld_write(input int idx, input logic [31:0] val);
        ld_en = 1'b1; ld_addr = 10'(idx); ld_data = val;
        mem_model[idx] = val;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic fetch(input int s, input logic [31:0] a, input int stall,
                         input bit ld_entry, input logic [31:0] ld_val, output time t_acc);
        logic [31:0] d_exp;
        logic        e_exp;
        int          n, k, lat, idx;
        lat = lat_of[s];
        model_rsp(a, d_exp, e_exp);
        idx = int'((a - BASE) >> 2) % DEPTH;
        req_valid[s] = 1'b1;
        req_addr[s]  = a;
        rsp_ready[s] = (stall == 0);
        n = 0;
        while (!req_ready_w[s] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("accept_s%0d", s), 32'(n < 20), 32'd1);
        t_acc = $time;
        @(negedge clk);
        req_valid[s] = 1'b0;
        req_addr[s]  = 32'hA5A5_A5A5;
        k = 0;
        while (!rsp_valid_w[s] && k < 40) begin
            if (ld_entry && k == lat - 1) begin
                ld_en = 1'b1; ld_addr = 10'(idx); ld_data = ld_val;
            end
            @(negedge clk);
            ld_en = 1'b0;
            k++;
        end
        if (ld_entry) mem_model[idx] = ld_val;
        chk($sformatf("latency_s%0d", s), k, lat);
        chk($sformatf("data_s%0d_%h", s, a), rsp_data_w[s], d_exp);
        chk($sformatf("err_s%0d_%h", s, a), 32'(rsp_err_w[s]), 32'(e_exp));
        chk($sformatf("busy_s%0d", s), 32'(busy_w[s]), 32'd1);
        chk($sformatf("req_rdy_lo_s%0d", s), 32'(req_ready_w[s]), 32'd0);
        for (int i = 0; i < stall; i++) begin
            if (i == 0 && !e_exp) begin
                ld_en = 1'b1; ld_addr = 10'(idx); ld_data = $urandom;
                mem_model[idx] = ld_data;
            end
            @(negedge clk);
            ld_en = 1'b0;
            chk($sformatf("hold_vld_s%0d", s), 32'(rsp_valid_w[s]), 32'd1);
            chk($sformatf("hold_data_s%0d", s), rsp_data_w[s], d_exp);
            chk($sformatf("hold_err_s%0d", s), 32'(rsp_err_w[s]), 32'(e_exp));
            chk($sformatf("hold_rdy_s%0d", s), 32'(req_ready_w[s]), 32'd0);
        end
        rsp_ready[s] = 1'b1;
        @(negedge clk);
        rsp_ready[s] = 1'b0;
        chk($sformatf("vld_clr_s%0d", s), 32'(rsp_valid_w[s]), 32'd0);
        chk($sformatf("rdy_back_s%0d", s), 32'(req_ready_w[s]), 32'd1);
        chk($sformatf("busy_clr_s%0d", s), 32'(busy_w[s]), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 5))
            0, 1, 2: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            3:       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            4:       a = 32'($urandom_range(0, 32'h7FFF_FFFF)) & 32'hFFFF_FFFC;
            default: a = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC
                                                     : BASE + 32'h1000 + 32'(4 * $urandom_range(0, 4000));
        endcase
        return a;
    endfunction

    initial begin
        time t_acc, t_prev;
        reset = 1'b1; req_valid = '0; rsp_ready = '0; req_addr = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst_vld_s%0d", s), 32'(rsp_valid_w[s]), 32'd0);
            chk($sformatf("rst_data_s%0d", s), rsp_data_w[s], 32'd0);
            chk($sformatf("rst_err_s%0d", s), 32'(rsp_err_w[s]), 32'd0);
            chk($sformatf("rst_busy_s%0d", s), 32'(busy_w[s]), 32'd0);
            chk($sformatf("rst_rdy_s%0d", s), 32'(req_ready_w[s]), 32'd1);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) ld_write(i, $urandom);
        ld_write(0, 32'h0000_0413);
        ld_write(1, 32'h0010_0073);

        fetch(0, 32'h8000_0000, 0, 1'b0, 32'd0, t_acc);
        fetch(1, 32'h8000_0004, 3, 1'b0, 32'd0, t_acc);
        fetch(0, 32'h8000_0002, 0, 1'b0, 32'd0, t_acc);
        fetch(0, 32'h7FFF_FFFC, 1, 1'b0, 32'd0, t_acc);
        fetch(0, 32'h8000_1000, 0, 1'b0, 32'd0, t_acc);
        fetch(2, 32'hFFFF_FFFC, 0, 1'b0, 32'd0, t_acc);
        fetch(1, 32'h8000_0FFC, 0, 1'b0, 32'd0, t_acc);

        fetch(0, 32'h8000_0008, 0, 1'b1, 32'hDEAD_BEEF, t_acc);
        fetch(0, 32'h8000_0008, 0, 1'b0, 32'd0, t_acc);
        chk("rbw_new_word", rsp_data_w[0], 32'hDEAD_BEEF);

        // Reset lands two cycles into a latency-3 wait; the pending fetch must vanish.
        fetch(2, 32'h8000_0010, 0, 1'b0, 32'd0, t_acc);
        req_valid[2] = 1'b1; req_addr[2] = 32'h8000_0014;
        @(negedge clk);
        req_valid[2] = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_vld", 32'(rsp_valid_w[2]), 32'd0);
        chk("arst_data", rsp_data_w[2], 32'd0);
        chk("arst_err", 32'(rsp_err_w[2]), 32'd0);
        chk("arst_busy", 32'(busy_w[2]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(rsp_valid_w[2]), 32'd0);
        end
        fetch(2, 32'h8000_0014, 2, 1'b0, 32'd0, t_acc);

        for (int i = 0; i < 8; i++) begin
            t_prev = t_acc;
            fetch(0, BASE + 32'(4 * i), 0, 1'b0, 32'd0, t_acc);
            if (i > 0) chk("b2b_spacing", 32'(t_acc - t_prev), 32'd30);
        end

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) ld_write($urandom_range(0, DEPTH - 1), $urandom);
            fetch($urandom_range(0, 2), rand_addr(), $urandom_range(0, 2), 1'b0, 32'd0, t_acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
